// File: rtl/ws2812_rx.sv
// WS2812 single-wire receive decoder.
// Classifies high pulses, assembles GRB pixels, detects latch gaps.
module ws2812_rx #(
  parameter logic [15:0] CNT_BIT_THR  = 16'd120,
  parameter logic [15:0] CNT_HIGH_MAX = 16'd400,
  parameter logic [15:0] CNT_RST      = 16'd10000,
  parameter logic [6:0]  PIXEL_MAX    = 7'd64
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        data_in,
  output logic        pixel_vld_out,
  output logic [5:0]  pixel_idx_out,
  output logic [23:0] pixel_data_out,
  output logic        frame_done_out,
  output logic [6:0]  frame_len_out,
  output logic        frame_ovf_out,
  output logic        err_out
);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_s1, r_s2, r_s3;
  logic [15:0] r_cnt;
  logic [15:0] w_cur;
  logic        w_rise, w_fall;
  logic [23:0] r_shift;
  logic [23:0] w_word;
  logic [4:0]  r_bit_cnt;
  logic [6:0]  r_pix_cnt;
  logic        r_ovf;
  logic        w_shift, w_bit, w_gap, w_to, w_sync_done;
  logic        w_last, w_frame_end;
  logic        r_vld, r_done, r_fovf, r_err;
  logic [5:0]  r_idx;
  logic [23:0] r_data;
  logic [6:0]  r_len;

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;
  // Cycles spent at the current s2 level, including this one.
  assign w_cur  = (w_rise | w_fall) ? 16'd1 :
                  (r_cnt >= CNT_RST) ? CNT_RST : r_cnt + 16'd1;
  assign w_word = {r_shift[22:0], w_bit};
  assign w_last = w_shift && (r_bit_cnt == 5'd23);
  assign w_frame_end = w_gap && ((r_pix_cnt != 7'd0) || (r_bit_cnt != 5'd0));

  // Two-stage synchronizer plus edge-detect flop.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= data_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Level width counter; after a fall it holds the finished high width.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_cnt <= 16'd0;
    else           r_cnt <= w_cur;
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= SYNC;
    else           r_state <= w_next;
  end

  // Next state and per-cycle control decisions.
  always_comb begin
    w_next      = r_state;
    w_shift     = 1'b0;
    w_bit       = 1'b0;
    w_gap       = 1'b0;
    w_to        = 1'b0;
    w_sync_done = 1'b0;
    case (r_state)
      SYNC: begin
        if (!r_s2 && (w_cur >= CNT_RST)) begin
          w_next      = LOW;
          w_sync_done = 1'b1;
        end
      end
      LOW: begin
        if (w_rise)                 w_next = HIGH;
        else if (w_cur >= CNT_RST)  w_gap  = 1'b1;
      end
      HIGH: begin
        if (w_fall) begin
          w_shift = 1'b1;
          w_bit   = (r_cnt >= CNT_BIT_THR);
          w_next  = LOW;
        end else if (w_cur >= CNT_HIGH_MAX + 16'd1) begin
          w_to   = 1'b1;
          w_next = SYNC;
        end
      end
      default: w_next = SYNC;
    endcase
  end

  // Bit assembly, pixel/frame bookkeeping and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_shift   <= 24'd0;
      r_bit_cnt <= 5'd0;
      r_pix_cnt <= 7'd0;
      r_ovf     <= 1'b0;
      r_vld     <= 1'b0;
      r_idx     <= 6'd0;
      r_data    <= 24'd0;
      r_done    <= 1'b0;
      r_len     <= 7'd0;
      r_fovf    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_vld  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_to || w_sync_done) begin
        r_bit_cnt <= 5'd0;
        r_pix_cnt <= 7'd0;
        r_ovf     <= 1'b0;
        r_err     <= w_to;
      end else if (w_frame_end) begin
        r_done    <= 1'b1;
        r_len     <= r_pix_cnt;
        r_fovf    <= r_ovf;
        r_err     <= (r_bit_cnt != 5'd0);
        r_bit_cnt <= 5'd0;
        r_pix_cnt <= 7'd0;
        r_ovf     <= 1'b0;
      end else if (w_shift) begin
        r_shift <= w_word;
        if (w_last) begin
          r_bit_cnt <= 5'd0;
          if (r_pix_cnt < PIXEL_MAX) begin
            r_vld     <= 1'b1;
            r_idx     <= r_pix_cnt[5:0];
            r_data    <= w_word;
            r_pix_cnt <= r_pix_cnt + 7'd1;
          end else begin
            r_ovf <= 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 5'd1;
        end
      end
    end
  end

  assign pixel_vld_out  = r_vld;
  assign pixel_idx_out  = r_idx;
  assign pixel_data_out = r_data;
  assign frame_done_out = r_done;
  assign frame_len_out  = r_len;
  assign frame_ovf_out  = r_fovf;
  assign err_out        = r_err;

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx.
// Timing parameters are scaled down 10x to keep runs short.
`timescale 1ns/1ps
module tb_ws2812_rx;

  localparam logic [15:0] THR  = 16'd12;
  localparam logic [15:0] HMAX = 16'd40;
  localparam logic [15:0] RST  = 16'd1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        pixel_vld_out;
  logic [5:0]  pixel_idx_out;
  logic [23:0] pixel_data_out;
  logic        frame_done_out;
  logic [6:0]  frame_len_out;
  logic        frame_ovf_out;
  logic        err_out;

  ws2812_rx #(
    .CNT_BIT_THR (THR),
    .CNT_HIGH_MAX(HMAX),
    .CNT_RST     (RST),
    .PIXEL_MAX   (7'd64)
  ) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .data_in       (din),
    .pixel_vld_out (pixel_vld_out),
    .pixel_idx_out (pixel_idx_out),
    .pixel_data_out(pixel_data_out),
    .frame_done_out(frame_done_out),
    .frame_len_out (frame_len_out),
    .frame_ovf_out (frame_ovf_out),
    .err_out       (err_out)
  );

  always #2.5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_err = 0;
  int          vidx[$];
  logic [23:0] vdat[$];
  int          dlen[$];
  logic        dovf[$];
  logic        derr[$];
  int          bv, bd, be;

  always @(negedge clk) begin
    if (pixel_vld_out) begin
      vidx.push_back(int'(pixel_idx_out));
      vdat.push_back(pixel_data_out);
    end
    if (frame_done_out) begin
      dlen.push_back(int'(frame_len_out));
      dovf.push_back(frame_ovf_out);
      derr.push_back(err_out);
    end
    if (err_out) n_err++;
  end

  task automatic mark();
    bv = vidx.size();
    bd = dlen.size();
    be = n_err;
  endtask

  task automatic send_raw(input int th, input int tl);
    din = 1'b1;
    repeat (th) @(negedge clk);
    din = 1'b0;
    repeat (tl) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int per);
    int th;
    th = b ? 16 : 8;
    send_raw(th, per - th);
  endtask

  task automatic send_pixel(input logic [23:0] d, input int per);
    for (int i = 23; i >= 0; i--) send_bit(d[i], per);
  endtask

  task automatic gap();
    din = 1'b0;
    repeat (int'(RST) + 50) @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    n_chk++;
    if ({pixel_vld_out, pixel_idx_out, pixel_data_out, frame_done_out,
         frame_len_out, frame_ovf_out, err_out} !== 41'd0) begin
      n_fail++;
      $display("FAIL %s_outs: got vld=%b idx=%0d data=%h done=%b len=%0d ovf=%b err=%b want all 0",
               tag, pixel_vld_out, pixel_idx_out, pixel_data_out,
               frame_done_out, frame_len_out, frame_ovf_out, err_out);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din = 1'b0;
    repeat (4) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    gap();
    n_chk++;
    if (vidx.size() + dlen.size() + n_err !== 0) begin
      n_fail++;
      $display("FAIL sync_quiet: got %0d events want 0",
               vidx.size() + dlen.size() + n_err);
    end
  endtask

  task automatic test_frame();
    logic [23:0] exp_d [3];
    exp_d = '{24'hFF0000, 24'h00AA55, 24'h000001};
    mark();
    for (int i = 0; i < 3; i++) send_pixel(exp_d[i], 25);
    gap();
    n_chk++;
    if (vidx.size() - bv !== 3) begin
      n_fail++;
      $display("FAIL frame_npix: got %0d want 3", vidx.size() - bv);
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (vidx[bv+i] !== i || vdat[bv+i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL frame_pix%0d: got idx=%0d data=%h want idx=%0d data=%h",
                 i, vidx[bv+i], vdat[bv+i], i, exp_d[i]);
      end
    end
    n_chk++;
    if (dlen.size() - bd !== 1 || dlen[bd] !== 3 || dovf[bd] !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_done: got n=%0d len=%0d ovf=%b want n=1 len=3 ovf=0",
               dlen.size() - bd, dlen[bd], dovf[bd]);
    end
    n_chk++;
    if (n_err - be !== 0) begin
      n_fail++;
      $display("FAIL frame_err: got %0d want 0", n_err - be);
    end
  endtask

  // Bit23 high THR-1 -> 0, bit22 high THR -> 1, bit21 high HMAX -> 1,
  // and a RST-1 low after bit12 that must not end the frame.
  task automatic test_threshold();
    int th, tl;
    mark();
    for (int i = 23; i >= 0; i--) begin
      th = (i == 23) ? int'(THR) - 1 :
           (i == 22) ? int'(THR) :
           (i == 21) ? int'(HMAX) : 8;
      tl = (i == 12) ? int'(RST) - 1 : 12;
      send_raw(th, tl);
    end
    gap();
    n_chk++;
    if (vidx.size() - bv !== 1 || vdat[bv] !== 24'h600000) begin
      n_fail++;
      $display("FAIL thr_word: got n=%0d data=%h want n=1 data=600000",
               vidx.size() - bv, vdat[bv]);
    end
    n_chk++;
    if (dlen.size() - bd !== 1 || dlen[bd] !== 1 || n_err - be !== 0) begin
      n_fail++;
      $display("FAIL thr_frame: got done=%0d len=%0d err=%0d want 1 1 0",
               dlen.size() - bd, dlen[bd], n_err - be);
    end
  endtask

  task automatic test_overflow();
    int bad;
    mark();
    for (int p = 0; p < 66; p++) send_pixel(24'h123456, 20);
    gap();
    n_chk++;
    if (vidx.size() - bv !== 64) begin
      n_fail++;
      $display("FAIL ovf_npix: got %0d want 64", vidx.size() - bv);
    end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      n_chk++;
      if (vidx[bv+i] !== i || vdat[bv+i] !== 24'h123456) begin
        n_fail++;
        bad++;
        if (bad < 4)
          $display("FAIL ovf_pix%0d: got idx=%0d data=%h want idx=%0d data=123456",
                   i, vidx[bv+i], vdat[bv+i], i);
      end
    end
    n_chk++;
    if (dlen.size() - bd !== 1 || dlen[bd] !== 64 || dovf[bd] !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_done: got n=%0d len=%0d ovf=%b want n=1 len=64 ovf=1",
               dlen.size() - bd, dlen[bd], dovf[bd]);
    end
    n_chk++;
    if (n_err - be !== 0) begin
      n_fail++;
      $display("FAIL ovf_err: got %0d want 0", n_err - be);
    end
  endtask

  task automatic test_partial();
    mark();
    for (int i = 0; i < 10; i++) send_bit(i[0], 25);
    gap();
    n_chk++;
    if (vidx.size() - bv !== 0) begin
      n_fail++;
      $display("FAIL part_npix: got %0d want 0", vidx.size() - bv);
    end
    n_chk++;
    if (dlen.size() - bd !== 1 || dlen[bd] !== 0 || derr[bd] !== 1'b1 ||
        n_err - be !== 1) begin
      n_fail++;
      $display("FAIL part_done: got n=%0d len=%0d err_with=%b nerr=%0d want 1 0 1 1",
               dlen.size() - bd, dlen[bd], derr[bd], n_err - be);
    end
    mark();
    send_pixel(24'hA5C3E1, 25);
    gap();
    n_chk++;
    if (vidx.size() - bv !== 1 || vidx[bv] !== 0 || vdat[bv] !== 24'hA5C3E1) begin
      n_fail++;
      $display("FAIL part_next: got n=%0d idx=%0d data=%h want 1 0 a5c3e1",
               vidx.size() - bv, vidx[bv], vdat[bv]);
    end
    n_chk++;
    if (dlen.size() - bd !== 1 || dlen[bd] !== 1 || n_err - be !== 0) begin
      n_fail++;
      $display("FAIL part_next_done: got n=%0d len=%0d err=%0d want 1 1 0",
               dlen.size() - bd, dlen[bd], n_err - be);
    end
  endtask

  task automatic test_high_timeout();
    mark();
    for (int i = 0; i < 5; i++) send_bit(~i[0], 25);
    send_raw(int'(HMAX) + 1, 20);
    send_pixel(24'h0F0F0F, 25);
    gap();
    n_chk++;
    if (n_err - be !== 1) begin
      n_fail++;
      $display("FAIL to_err: got %0d want 1", n_err - be);
    end
    n_chk++;
    if (dlen.size() - bd !== 0 || vidx.size() - bv !== 0) begin
      n_fail++;
      $display("FAIL to_quiet: got done=%0d pix=%0d want 0 0",
               dlen.size() - bd, vidx.size() - bv);
    end
    mark();
    send_pixel(24'h00FF00, 25);
    gap();
    n_chk++;
    if (vidx.size() - bv !== 1 || vidx[bv] !== 0 || vdat[bv] !== 24'h00FF00 ||
        dlen.size() - bd !== 1 || dlen[bd] !== 1) begin
      n_fail++;
      $display("FAIL to_fresh: got n=%0d idx=%0d data=%h done=%0d len=%0d want 1 0 00ff00 1 1",
               vidx.size() - bv, vidx[bv], vdat[bv], dlen.size() - bd, dlen[bd]);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] part;
    part = 12'hABC;
    mark();
    for (int p = 0; p < 5; p++) send_pixel(24'h0000FF + 24'(p), 25);
    for (int i = 11; i >= 0; i--) send_bit(part[i], 25);
    n_chk++;
    if (vidx.size() - bv !== 5 || vidx[bv+4] !== 4 || vdat[bv+4] !== 24'h000103) begin
      n_fail++;
      $display("FAIL mid_pre: got n=%0d idx=%0d data=%h want 5 4 000103",
               vidx.size() - bv, vidx[bv+4], vdat[bv+4]);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_outputs_zero("midrst");
    rst_n = 1'b1;
    mark();
    send_pixel(24'h111111, 25);
    gap();
    n_chk++;
    if (vidx.size() - bv !== 0 || dlen.size() - bd !== 0 || n_err - be !== 0) begin
      n_fail++;
      $display("FAIL mid_sync: got pix=%0d done=%0d err=%0d want 0 0 0",
               vidx.size() - bv, dlen.size() - bd, n_err - be);
    end
    mark();
    send_pixel(24'h222222, 25);
    gap();
    n_chk++;
    if (vidx.size() - bv !== 1 || vidx[bv] !== 0 || vdat[bv] !== 24'h222222 ||
        dlen.size() - bd !== 1 || dlen[bd] !== 1) begin
      n_fail++;
      $display("FAIL mid_next: got n=%0d idx=%0d data=%h done=%0d len=%0d want 1 0 222222 1 1",
               vidx.size() - bv, vidx[bv], vdat[bv], dlen.size() - bd, dlen[bd]);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_frame();
    test_threshold();
    test_overflow();
    test_partial();
    test_high_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
